// File: rtl/l2_req_arbiter_pkg.sv
// l2_req_arbiter_pkg: shared widths, port indices and request record for the L2 request arbiter
package l2_req_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WIDTH = 256;
  localparam int MSHR_ID_BITS = 3;
  localparam int TAG_BITS = MSHR_ID_BITS + 1;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
    logic rw;
    logic [MSHR_ID_BITS-1:0] id;
  } req_t;
endpackage

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if: L1 request/response ports and the shared L2 port of the arbiter
interface l2_req_arbiter_if;
  import l2_req_arbiter_pkg::*;
  logic [1:0][ADDR_WIDTH-1:0] rq_addr_i;
  logic [1:0][LINE_WIDTH-1:0] rq_data_i;
  logic [1:0] rq_rw_i;
  logic [1:0] rq_valid_i;
  logic [1:0][MSHR_ID_BITS-1:0] rq_id_i;
  logic [1:0] rq_stall_o;
  logic [1:0][LINE_WIDTH-1:0] rs_data_o;
  logic [1:0][MSHR_ID_BITS-1:0] rs_id_o;
  logic [1:0] rs_valid_o;
  logic [ADDR_WIDTH-1:0] l2_addr_o;
  logic [LINE_WIDTH-1:0] l2_data_o;
  logic l2_rw_o;
  logic l2_valid_o;
  logic [TAG_BITS-1:0] l2_id_o;
  logic l2_stall_i;
  logic [LINE_WIDTH-1:0] l2_data_i;
  logic [TAG_BITS-1:0] l2_id_i;
  logic l2_ready_i;
  modport slave (
    input rq_addr_i, rq_data_i, rq_rw_i, rq_valid_i, rq_id_i, l2_stall_i, l2_data_i, l2_id_i, l2_ready_i,
    output rq_stall_o, rs_data_o, rs_id_o, rs_valid_o, l2_addr_o, l2_data_o, l2_rw_o, l2_valid_o, l2_id_o
  );
  modport master (
    output rq_addr_i, rq_data_i, rq_rw_i, rq_valid_i, rq_id_i, l2_stall_i, l2_data_i, l2_id_i, l2_ready_i,
    input rq_stall_o, rs_data_o, rs_id_o, rs_valid_o, l2_addr_o, l2_data_o, l2_rw_o, l2_valid_o, l2_id_o
  );
endinterface

// File: rtl/l2_req_hold_slot.sv
// l2_req_hold_slot: one-entry request holding register with outstanding-read throttle
module l2_req_hold_slot
  import l2_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  req_t req_i,
  input  logic grant_i,
  input  logic rsp_i,
  output logic stall_o,
  output logic hold_valid_o,
  output req_t hold_o
);
  logic hv_q, hv_d, cap, inc, dec;
  req_t hold_q, hold_d;
  logic [TAG_BITS-1:0] cnt_q, cnt_d;
  always_comb begin
    stall_o = hv_q | (cnt_q == TAG_BITS'(MAX_OUTSTANDING));
    cap = valid_i & ~stall_o;
    inc = cap & ~req_i.rw;
    dec = rsp_i & (cnt_q != '0);
    hv_d = cap | (hv_q & ~grant_i);
    hold_d = cap ? req_i : hold_q;
    cnt_d = cnt_q + TAG_BITS'(inc) - TAG_BITS'(dec);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hv_q <= 1'b0;
      hold_q <= '0;
      cnt_q <= '0;
    end else begin
      hv_q <= hv_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
    end
  end
  assign hold_valid_o = hv_q;
  assign hold_o = hold_q;
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin sharing of the L2 request port between I-L1 and D-L1, with tagged response routing
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic reset,
  l2_req_arbiter_if.slave bus
);
  req_t req0, req1, hold [2];
  logic [1:0] hv, elig, grant, rsp, stall;
  logic last_q, last_d, any_g, g, src;
  always_comb begin
    req0 = '{bus.rq_addr_i[0], bus.rq_data_i[0], bus.rq_rw_i[0], bus.rq_id_i[0]};
    req1 = '{bus.rq_addr_i[1], bus.rq_data_i[1], bus.rq_rw_i[1], bus.rq_id_i[1]};
    elig = hv & {2{~bus.l2_stall_i}};
    any_g = |elig;
    g = (&elig) ? ~last_q : elig[1];
    grant = any_g ? (g ? 2'b10 : 2'b01) : 2'b00;
    last_d = any_g ? g : last_q;
    src = bus.l2_id_i[TAG_BITS-1];
    rsp = bus.l2_ready_i ? (src ? 2'b10 : 2'b01) : 2'b00;
  end
  l2_req_hold_slot #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_slot0 (
    .clk(clk), .reset(reset), .valid_i(bus.rq_valid_i[0]), .req_i(req0), .grant_i(grant[0]),
    .rsp_i(rsp[0]), .stall_o(stall[0]), .hold_valid_o(hv[0]), .hold_o(hold[0])
  );
  l2_req_hold_slot #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_slot1 (
    .clk(clk), .reset(reset), .valid_i(bus.rq_valid_i[1]), .req_i(req1), .grant_i(grant[1]),
    .rsp_i(rsp[1]), .stall_o(stall[1]), .hold_valid_o(hv[1]), .hold_o(hold[1])
  );
  assign bus.rq_stall_o = stall;
  // last_q is the last granted port; it resets to PORT_D so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_D;
      bus.l2_valid_o <= 1'b0;
      bus.l2_rw_o <= 1'b0;
      bus.l2_addr_o <= '0;
      bus.l2_data_o <= '0;
      bus.l2_id_o <= '0;
      bus.rs_valid_o <= '0;
      bus.rs_data_o <= '0;
      bus.rs_id_o <= '0;
    end else begin
      last_q <= last_d;
      bus.l2_valid_o <= any_g;
      if (any_g) begin
        bus.l2_addr_o <= hold[g].addr;
        bus.l2_data_o <= hold[g].data;
        bus.l2_rw_o <= hold[g].rw;
        bus.l2_id_o <= {g, hold[g].id};
      end
      bus.rs_valid_o <= rsp;
      if (bus.l2_ready_i) begin
        bus.rs_data_o[src] <= bus.l2_data_i;
        bus.rs_id_o[src] <= bus.l2_id_i[MSHR_ID_BITS-1:0];
      end
    end
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: table-driven and directed checks of the L2 request arbiter
module tb_l2_req_arbiter;
  import l2_req_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  l2_req_arbiter_if bus();
  l2_req_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0] v;
    logic [1:0] rw;
    logic [2:0] id0;
    logic [2:0] id1;
    logic l2s;
    logic rdy;
    logic [3:0] rid;
    logic [1:0] e_stall;
    logic e_lv;
    logic [3:0] e_lid;
    logic [1:0] e_rsv;
    logic [3:0] e_c0;
    logic [3:0] e_c1;
  } vec_t;
  vec_t tbl [19];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic idle;
    bus.rq_valid_i = '0;
    bus.rq_rw_i = '0;
    bus.rq_addr_i[0] = 32'h1000;
    bus.rq_addr_i[1] = 32'h2000;
    bus.rq_data_i = '0;
    bus.rq_id_i = '0;
    bus.l2_stall_i = 1'b0;
    bus.l2_ready_i = 1'b0;
    bus.l2_id_i = '0;
    bus.l2_data_i = '0;
  endtask
  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{2'b11, 2'b00, 3'd1, 3'd2, 1'b0, 1'b0, 4'h0, 2'b11, 1'b0, 4'h0, 2'b00, 4'd1, 4'd1};
    tbl[1]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b10, 1'b1, 4'h1, 2'b00, 4'd1, 4'd1};
    tbl[2]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00, 4'd1, 4'd1};
    tbl[3]  = '{2'b11, 2'b00, 3'd5, 3'd6, 1'b0, 1'b0, 4'h0, 2'b11, 1'b0, 4'hA, 2'b00, 4'd2, 4'd2};
    tbl[4]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b10, 1'b1, 4'h5, 2'b00, 4'd2, 4'd2};
    tbl[5]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'hE, 2'b00, 4'd2, 4'd2};
    tbl[6]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'h1, 2'b00, 1'b0, 4'hE, 2'b01, 4'd1, 4'd2};
    tbl[7]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'hA, 2'b00, 1'b0, 4'hE, 2'b10, 4'd1, 4'd1};
    tbl[8]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'h5, 2'b00, 1'b0, 4'hE, 2'b01, 4'd0, 4'd1};
    tbl[9]  = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'hE, 2'b00, 1'b0, 4'hE, 2'b10, 4'd0, 4'd0};
    tbl[10] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'hE, 2'b00, 4'd0, 4'd0};
    tbl[11] = '{2'b01, 2'b00, 3'd3, 3'd0, 1'b0, 1'b0, 4'h0, 2'b01, 1'b0, 4'hE, 2'b00, 4'd1, 4'd0};
    tbl[12] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'h3, 2'b00, 4'd1, 4'd0};
    tbl[13] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h3, 2'b00, 4'd1, 4'd0};
    tbl[14] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'h3, 2'b00, 1'b0, 4'h3, 2'b01, 4'd0, 4'd0};
    tbl[15] = '{2'b01, 2'b00, 3'd4, 3'd0, 1'b0, 1'b0, 4'h0, 2'b01, 1'b0, 4'h3, 2'b00, 4'd1, 4'd0};
    tbl[16] = '{2'b01, 2'b00, 3'd7, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'h4, 2'b00, 4'd1, 4'd0};
    tbl[17] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h4, 2'b00, 4'd1, 4'd0};
    tbl[18] = '{2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 1'b1, 4'h4, 2'b00, 1'b0, 4'h4, 2'b01, 4'd0, 4'd0};
    do_reset();
    chk("rst.stall", bus.rq_stall_o, 2'b00);
    chk("rst.l2_valid", bus.l2_valid_o, 1'b0);
    chk("rst.l2_id", bus.l2_id_o, 4'h0);
    chk("rst.l2_addr", bus.l2_addr_o, 32'h0);
    chk("rst.rs_valid", bus.rs_valid_o, 2'b00);
    chk("rst.cnt0", dut.u_slot0.cnt_q, 4'd0);
    chk("rst.cnt1", dut.u_slot1.cnt_q, 4'd0);
    for (int i = 0; i < 19; i++) begin
      bus.rq_valid_i = tbl[i].v;
      bus.rq_rw_i = tbl[i].rw;
      bus.rq_id_i[0] = tbl[i].id0;
      bus.rq_id_i[1] = tbl[i].id1;
      bus.l2_stall_i = tbl[i].l2s;
      bus.l2_ready_i = tbl[i].rdy;
      bus.l2_id_i = tbl[i].rid;
      bus.l2_data_i = {8{28'h0, tbl[i].rid}};
      tick();
      chk($sformatf("v%0d.stall", i), bus.rq_stall_o, tbl[i].e_stall);
      chk($sformatf("v%0d.l2_valid", i), bus.l2_valid_o, tbl[i].e_lv);
      chk($sformatf("v%0d.l2_id", i), bus.l2_id_o, tbl[i].e_lid);
      chk($sformatf("v%0d.rs_valid", i), bus.rs_valid_o, tbl[i].e_rsv);
      chk($sformatf("v%0d.cnt0", i), dut.u_slot0.cnt_q, tbl[i].e_c0);
      chk($sformatf("v%0d.cnt1", i), dut.u_slot1.cnt_q, tbl[i].e_c1);
      if (tbl[i].e_lv)
        chk($sformatf("v%0d.l2_addr", i), bus.l2_addr_o, tbl[i].e_lid[3] ? 32'h2000 : 32'h1000);
      if (tbl[i].rdy) begin
        chk($sformatf("v%0d.rs_id", i), bus.rs_id_o[tbl[i].rid[3]], tbl[i].rid[2:0]);
        chk($sformatf("v%0d.rs_data", i), bus.rs_data_o[tbl[i].rid[3]], {8{28'h0, tbl[i].rid}});
      end
    end
    // L2 stall with both holds valid
    do_reset();
    bus.l2_stall_i = 1'b1;
    bus.rq_valid_i = 2'b11;
    bus.rq_id_i[0] = 3'd1;
    bus.rq_id_i[1] = 3'd2;
    tick();
    bus.rq_valid_i = 2'b00;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk($sformatf("l2stall%0d.valid", k), bus.l2_valid_o, 1'b0);
      chk($sformatf("l2stall%0d.stall", k), bus.rq_stall_o, 2'b11);
    end
    bus.l2_stall_i = 1'b0;
    tick();
    chk("l2stall.rel0.valid", bus.l2_valid_o, 1'b1);
    chk("l2stall.rel0.id", bus.l2_id_o, 4'h1);
    tick();
    chk("l2stall.rel1.valid", bus.l2_valid_o, 1'b1);
    chk("l2stall.rel1.id", bus.l2_id_o, 4'hA);
    // port 1 reaches its outstanding limit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.rq_valid_i = 2'b10;
      bus.rq_id_i[1] = 3'(k);
      tick();
      chk($sformatf("lim%0d.cap_stall1", k), bus.rq_stall_o[1], 1'b1);
      bus.rq_valid_i = 2'b00;
      tick();
      chk($sformatf("lim%0d.valid", k), bus.l2_valid_o, 1'b1);
      chk($sformatf("lim%0d.id", k), bus.l2_id_o, {1'b1, 3'(k)});
      chk($sformatf("lim%0d.stall1", k), bus.rq_stall_o[1], k == 3);
    end
    chk("lim.cnt1", dut.u_slot1.cnt_q, 4'd4);
    bus.rq_valid_i = 2'b01;
    bus.rq_id_i[0] = 3'd5;
    tick();
    chk("lim.p0cap.stall", bus.rq_stall_o, 2'b11);
    bus.rq_valid_i = 2'b00;
    tick();
    chk("lim.p0.valid", bus.l2_valid_o, 1'b1);
    chk("lim.p0.id", bus.l2_id_o, 4'h5);
    chk("lim.p0.stall", bus.rq_stall_o, 2'b10);
    bus.l2_ready_i = 1'b1;
    bus.l2_id_i = 4'h8;
    tick();
    bus.l2_ready_i = 1'b0;
    chk("lim.rsp.stall", bus.rq_stall_o, 2'b00);
    chk("lim.rsp.rs_valid", bus.rs_valid_o, 2'b10);
    chk("lim.rsp.rs_id", bus.rs_id_o[1], 3'd0);
    chk("lim.rsp.cnt1", dut.u_slot1.cnt_q, 4'd3);
    chk("lim.rsp.cnt0", dut.u_slot0.cnt_q, 4'd1);
    // port 0 write
    do_reset();
    bus.rq_valid_i = 2'b01;
    bus.rq_rw_i = 2'b01;
    bus.rq_addr_i[0] = 32'h3000;
    bus.rq_data_i[0] = {8{32'hDEADBEEF}};
    bus.rq_id_i[0] = 3'd6;
    tick();
    bus.rq_valid_i = 2'b00;
    chk("wr.cap.cnt0", dut.u_slot0.cnt_q, 4'd0);
    chk("wr.cap.stall", bus.rq_stall_o, 2'b01);
    tick();
    chk("wr.valid", bus.l2_valid_o, 1'b1);
    chk("wr.rw", bus.l2_rw_o, 1'b1);
    chk("wr.addr", bus.l2_addr_o, 32'h3000);
    chk("wr.data", bus.l2_data_o, {8{32'hDEADBEEF}});
    chk("wr.id", bus.l2_id_o, 4'h6);
    chk("wr.cnt0", dut.u_slot0.cnt_q, 4'd0);
    // reset with both holds valid and cnt1 = 2
    do_reset();
    bus.rq_valid_i = 2'b10;
    bus.rq_id_i[1] = 3'd1;
    tick();
    bus.rq_valid_i = 2'b00;
    tick();
    bus.l2_stall_i = 1'b1;
    bus.rq_valid_i = 2'b11;
    bus.rq_id_i[0] = 3'd2;
    bus.rq_id_i[1] = 3'd3;
    tick();
    bus.rq_valid_i = 2'b00;
    chk("mid.pre.cnt1", dut.u_slot1.cnt_q, 4'd2);
    chk("mid.pre.stall", bus.rq_stall_o, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.l2_stall_i = 1'b0;
    chk("mid.rst.stall", bus.rq_stall_o, 2'b00);
    chk("mid.rst.valid", bus.l2_valid_o, 1'b0);
    chk("mid.rst.cnt0", dut.u_slot0.cnt_q, 4'd0);
    chk("mid.rst.cnt1", dut.u_slot1.cnt_q, 4'd0);
    bus.l2_ready_i = 1'b1;
    bus.l2_id_i = 4'hA;
    bus.l2_data_i = {8{32'hCAFEF00D}};
    tick();
    bus.l2_ready_i = 1'b0;
    chk("mid.stray.rs_valid", bus.rs_valid_o, 2'b10);
    chk("mid.stray.rs_id", bus.rs_id_o[1], 3'd2);
    chk("mid.stray.rs_data", bus.rs_data_o[1], {8{32'hCAFEF00D}});
    chk("mid.stray.cnt1", dut.u_slot1.cnt_q, 4'd0);
    chk("mid.stray.valid", bus.l2_valid_o, 1'b0);
    tick();
    chk("mid.after.rs_valid", bus.rs_valid_o, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
